// File: rtl/decode_stage.sv
// RV32 decode stage: combinational regfile address select and classification, registered valid/ready bundle
// with load-use interlock and flush. Optional stall counter port under `DECODE_STALL_CNT_EN.
module decode_stage #(
    parameter int  XLEN     = 32,
    parameter int  NUM_REGS = 32,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [31:0]       if_instr_i,
    input  logic [XLEN-1:0]   if_pc_i,
    input  logic              flush_i,
    output logic [REG_AW-1:0] sel_rs1_o,
    output logic [REG_AW-1:0] sel_rs2_o,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [31:0]       ex_instr_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_is_load_o,
    output logic              ex_illegal_o
`ifdef DECODE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Only the RV32E file can see an out-of-range index (field bit 4 set).
    localparam logic NARROW_RF = (NUM_REGS < 32) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    logic [6:0]        opcode_s;
    logic [REG_AW-1:0] rs1_f_s;
    logic [REG_AW-1:0] rs2_f_s;
    logic [REG_AW-1:0] rd_f_s;
    logic              uses_rs1_s;
    logic              uses_rs2_s;
    logic              has_rd_s;
    logic              is_load_s;
    logic              illegal_op_s;
    logic              reg_bad_s;
    logic              hz_s;
    logic              adv_s;
    fmt_e              fmt_s;
    logic [31:0]       imm32_s;
    logic [XLEN-1:0]   imm_s;

    assign opcode_s = if_instr_i[6:0];
    assign rs1_f_s  = if_instr_i[15 +: REG_AW];
    assign rs2_f_s  = if_instr_i[20 +: REG_AW];
    assign rd_f_s   = if_instr_i[7 +: REG_AW];

    // Opcode classification: register usage, immediate format, legality.
    always_comb begin
        uses_rs1_s   = 1'b0;
        uses_rs2_s   = 1'b0;
        has_rd_s     = 1'b0;
        is_load_s    = 1'b0;
        illegal_op_s = 1'b0;
        fmt_s        = FMT_NONE;
        case (opcode_s)
            OP_R:      begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; has_rd_s = 1'b1; end
            OP_I:      begin uses_rs1_s = 1'b1; has_rd_s = 1'b1; fmt_s = FMT_I; end
            OP_LOAD:   begin uses_rs1_s = 1'b1; has_rd_s = 1'b1; is_load_s = 1'b1; fmt_s = FMT_I; end
            OP_STORE:  begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; fmt_s = FMT_S; end
            OP_BRANCH: begin uses_rs1_s = 1'b1; uses_rs2_s = 1'b1; fmt_s = FMT_B; end
            OP_JAL:    begin has_rd_s = 1'b1; fmt_s = FMT_J; end
            OP_JALR:   begin uses_rs1_s = 1'b1; has_rd_s = 1'b1; fmt_s = FMT_I; end
            OP_LUI:    begin has_rd_s = 1'b1; fmt_s = FMT_U; end
            OP_AUIPC:  begin has_rd_s = 1'b1; fmt_s = FMT_U; end
            default:   illegal_op_s = 1'b1;
        endcase
    end

    // Immediate assembly per format, then sign-extension to XLEN.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
            FMT_S:   imm32_s = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
            FMT_B:   imm32_s = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                                if_instr_i[30:25], if_instr_i[11:8], 1'b0};
            FMT_U:   imm32_s = {if_instr_i[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                                if_instr_i[20], if_instr_i[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
        imm_s = XLEN'($signed(imm32_s));
    end

    assign reg_bad_s = NARROW_RF & ((uses_rs1_s & if_instr_i[19]) |
                                    (uses_rs2_s & if_instr_i[24]) |
                                    (has_rd_s   & if_instr_i[11]));

    assign adv_s = ex_ready_i | ~ex_valid_o;
    assign hz_s  = if_valid_i & ex_valid_o & ex_is_load_o & (ex_rd_o != {REG_AW{1'b0}}) &
                   ((uses_rs1_s & (rs1_f_s == ex_rd_o)) | (uses_rs2_s & (rs2_f_s == ex_rd_o)));

    assign if_ready_o = flush_i | (adv_s & ~hz_s);

    // Regfile read addresses; unused fields are forced to zero.
    always_comb begin
        if (if_valid_i & uses_rs1_s) begin
            sel_rs1_o = rs1_f_s;
        end else begin
            sel_rs1_o = {REG_AW{1'b0}};
        end
        if (if_valid_i & uses_rs2_s) begin
            sel_rs2_o = rs2_f_s;
        end else begin
            sel_rs2_o = {REG_AW{1'b0}};
        end
    end

    // Pipeline slot: flush beats hazard bubble beats load; payload only changes on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o   <= 1'b0;
            ex_instr_o   <= 32'd0;
            ex_pc_o      <= {XLEN{1'b0}};
            ex_imm_o     <= {XLEN{1'b0}};
            ex_rd_o      <= {REG_AW{1'b0}};
            ex_is_load_o <= 1'b0;
            ex_illegal_o <= 1'b0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (adv_s) begin
            if (hz_s) begin
                ex_valid_o <= 1'b0;
            end else if (if_valid_i) begin
                ex_valid_o   <= 1'b1;
                ex_instr_o   <= if_instr_i;
                ex_pc_o      <= if_pc_i;
                ex_imm_o     <= imm_s;
                ex_rd_o      <= has_rd_s ? rd_f_s : {REG_AW{1'b0}};
                ex_is_load_o <= is_load_s;
                ex_illegal_o <= illegal_op_s | reg_bad_s;
            end else begin
                ex_valid_o <= 1'b0;
            end
        end
    end

`ifdef DECODE_STALL_CNT_EN
    // Counts load-use bubbles actually inserted; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 32'd0;
        end else if (hz_s & adv_s & ~flush_i) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: an RV32I (32-reg) and an RV32E (16-reg) instance share stimulus and
// are compared against a behavioural model of the decode rules and slot priority.
module tb_decode_stage;

    localparam logic [31:0] ADD3  = 32'h002081B3;
    localparam logic [31:0] LW5   = 32'hFFC0A283;
    localparam logic [31:0] ADD6  = 32'h00028333;
    localparam logic [31:0] BEQ   = 32'hFE208CE3;
    localparam logic [31:0] LUI7  = 32'h123453B7;
    localparam logic [31:0] ADDI1 = 32'h00100093;
    localparam logic [31:0] ADDI2 = 32'h00200113;
    localparam logic [31:0] ADD17 = 32'h002088B3;

    logic clk = 1'b0;
    logic rst_n;
    logic if_valid, flush, ex_ready;
    logic [31:0] if_instr, if_pc;
    logic rdy0, rdy1, ev0, ev1, ld0, ld1, il0, il1;
    logic [4:0] s1_0, s2_0, rd0;
    logic [3:0] s1_1, s2_1, rd1;
    logic [31:0] ins0, ins1, pc0, pc1, im0, im1;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0] sc0, sc1;
`endif

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .if_ready_o(rdy0), .if_instr_i(if_instr),
        .if_pc_i(if_pc), .flush_i(flush), .sel_rs1_o(s1_0), .sel_rs2_o(s2_0), .ex_valid_o(ev0),
        .ex_ready_i(ex_ready), .ex_instr_o(ins0), .ex_pc_o(pc0), .ex_imm_o(im0), .ex_rd_o(rd0),
        .ex_is_load_o(ld0), .ex_illegal_o(il0)
`ifdef DECODE_STALL_CNT_EN
        , .stall_cnt_o(sc0)
`endif
    );

    decode_stage #(.XLEN(32), .NUM_REGS(16)) dut_e (
        .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .if_ready_o(rdy1), .if_instr_i(if_instr),
        .if_pc_i(if_pc), .flush_i(flush), .sel_rs1_o(s1_1), .sel_rs2_o(s2_1), .ex_valid_o(ev1),
        .ex_ready_i(ex_ready), .ex_instr_o(ins1), .ex_pc_o(pc1), .ex_imm_o(im1), .ex_rd_o(rd1),
        .ex_is_load_o(ld1), .ex_illegal_o(il1)
`ifdef DECODE_STALL_CNT_EN
        , .stall_cnt_o(sc1)
`endif
    );

    typedef struct packed {
        logic v; logic [31:0] instr; logic [31:0] pc; logic [31:0] imm; logic [4:0] rd; logic ld; logic ill;
    } bundle_t;

    typedef struct packed {
        logic u1; logic u2; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic ld; logic ill; logic [31:0] imm;
    } dec_t;

    bundle_t     m_b [2];
    logic [31:0] m_st [2];
    int n_vec = 0;
    int n_err = 0;

    function automatic int nr(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    // Decode from the ISA rules; immediates as weighted sums of the instruction fields.
    function automatic dec_t mdec(input logic [31:0] w, input int nregs);
        dec_t d;
        bit hr, known;
        int imm, i_imm, s_imm, b_imm, u_imm, j_imm;
        d = '0; hr = 0; known = 1; imm = 0;
        i_imm = int'(w[30:20]) - (w[31] ? 2048 : 0);
        s_imm = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
        b_imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
        u_imm = int'(w[31:12]) << 12;
        j_imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - (w[31] ? 1048576 : 0);
        case (w[6:0])
            7'h33:   begin d.u1 = 1; d.u2 = 1; hr = 1; end
            7'h13:   begin d.u1 = 1; hr = 1; imm = i_imm; end
            7'h03:   begin d.u1 = 1; hr = 1; d.ld = 1; imm = i_imm; end
            7'h23:   begin d.u1 = 1; d.u2 = 1; imm = s_imm; end
            7'h63:   begin d.u1 = 1; d.u2 = 1; imm = b_imm; end
            7'h6F:   begin hr = 1; imm = j_imm; end
            7'h67:   begin d.u1 = 1; hr = 1; imm = i_imm; end
            7'h37:   begin hr = 1; imm = u_imm; end
            7'h17:   begin hr = 1; imm = u_imm; end
            default: known = 0;
        endcase
        d.rs1 = 5'(int'(w[19:15]) % nregs);
        d.rs2 = 5'(int'(w[24:20]) % nregs);
        d.rd  = hr ? 5'(int'(w[11:7]) % nregs) : 5'd0;
        d.ill = !known || (d.u1 && int'(w[19:15]) >= nregs) || (d.u2 && int'(w[24:20]) >= nregs)
                || (hr && int'(w[11:7]) >= nregs);
        d.imm = 32'(imm);
        return d;
    endfunction

    function automatic logic m_hz(input int k);
        dec_t d;
        d = mdec(if_instr, nr(k));
        return if_valid && m_b[k].v && m_b[k].ld && (m_b[k].rd != 5'd0) &&
               ((d.u1 && d.rs1 == m_b[k].rd) || (d.u2 && d.rs2 == m_b[k].rd));
    endfunction

    function automatic logic m_ready(input int k);
        return flush || ((ex_ready || !m_b[k].v) && !m_hz(k));
    endfunction

    function automatic logic [10:0] exp_comb(input int k);
        dec_t d;
        d = mdec(if_instr, nr(k));
        return {m_ready(k), (if_valid && d.u1) ? d.rs1 : 5'd0, (if_valid && d.u2) ? d.rs2 : 5'd0};
    endfunction

    function automatic logic [10:0] got_comb(input int k);
        return (k == 0) ? {rdy0, s1_0, s2_0} : {rdy1, 1'b0, s1_1, 1'b0, s2_1};
    endfunction

    function automatic bundle_t got_b(input int k);
        bundle_t b;
        if (k == 0) begin
            b.v = ev0; b.instr = ins0; b.pc = pc0; b.imm = im0; b.rd = rd0; b.ld = ld0; b.ill = il0;
        end else begin
            b.v = ev1; b.instr = ins1; b.pc = pc1; b.imm = im1; b.rd = {1'b0, rd1}; b.ld = ld1; b.ill = il1;
        end
        return b;
    endfunction

    function automatic logic [31:0] got_st(input int k);
`ifdef DECODE_STALL_CNT_EN
        return (k == 0) ? sc0 : sc1;
`else
        return m_st[k];
`endif
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_b[k]  = '0;
            m_st[k] = 32'd0;
        end
    endtask

    // Advance the model with the current inputs across one rising edge.
    task automatic tick();
        bundle_t     nb [2];
        logic [31:0] ns [2];
        dec_t        d;
        logic        adv, hz;
        for (int k = 0; k < 2; k++) begin
            nb[k] = m_b[k]; ns[k] = m_st[k];
            adv = ex_ready || !m_b[k].v;
            hz  = m_hz(k);
            d   = mdec(if_instr, nr(k));
            if (flush) nb[k].v = 1'b0;
            else if (adv && hz) begin nb[k].v = 1'b0; ns[k] = ns[k] + 32'd1; end
            else if (adv && if_valid) nb[k] = '{1'b1, if_instr, if_pc, d.imm, d.rd, d.ld, d.ill};
            else if (adv) nb[k].v = 1'b0;
        end
        @(posedge clk);
        m_b = nb; m_st = ns;
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl, input logic rdy);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = rdy;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h33; 1: w[6:0] = 7'h13; 2: w[6:0] = 7'h03; 3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63; 5: w[6:0] = 7'h6F; 6: w[6:0] = 7'h67; 7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17; default: w[6:0] = 7'h7F;
        endcase
        if ($urandom_range(0, 3) != 0) begin
            w[11:7] = 5'($urandom_range(0, 7)); w[19:15] = 5'($urandom_range(0, 7)); w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    task automatic test_reset();
        m_reset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (got_b(k) !== m_b[k]) begin n_err++; $display("FAIL reset_bundle dut%0d got %h want %h", k, got_b(k), m_b[k]); end
            n_vec++; if (got_comb(k) !== exp_comb(k)) begin n_err++; $display("FAIL reset_comb dut%0d got %h want %h", k, got_comb(k), exp_comb(k)); end
            n_vec++; if (got_st(k) !== 32'd0) begin n_err++; $display("FAIL reset_stall dut%0d got %h want 0", k, got_st(k)); end
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        drive(1'b1, ADD3, 32'h100, 1'b0, 1'b1);
        #1;
        n_vec++; if ({s1_0, s2_0} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL add_sel got %0d/%0d want 1/2", s1_0, s2_0); end
        tick();
        if_valid = 1'b0;
        n_vec++; if ({ev0, rd0, im0} !== {1'b1, 5'd3, 32'd0}) begin n_err++; $display("FAIL add_ex got v=%b rd=%0d imm=%h want v=1 rd=3 imm=0", ev0, rd0, im0); end
        n_vec++; if (got_b(0) !== m_b[0]) begin n_err++; $display("FAIL add_model got %h want %h", got_b(0), m_b[0]); end
    endtask

    task automatic test_load_use();
        logic [31:0] st0;
        drive(1'b1, LW5, 32'h200, 1'b0, 1'b1);
        tick();
        n_vec++; if ({ev0, ld0, rd0, im0} !== {1'b1, 1'b1, 5'd5, 32'hFFFFFFFC}) begin n_err++; $display("FAIL lw_ex got v=%b ld=%b rd=%0d imm=%h", ev0, ld0, rd0, im0); end
        st0 = m_st[0];
        drive(1'b1, ADD6, 32'h204, 1'b0, 1'b1);
        #1;
        n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL lu_ready_low got %b want 0", rdy0); end
        n_vec++; if (got_comb(1) !== exp_comb(1)) begin n_err++; $display("FAIL lu_comb_e got %h want %h", got_comb(1), exp_comb(1)); end
        tick();
        n_vec++; if (ev0 !== 1'b0) begin n_err++; $display("FAIL lu_bubble got v=%b want 0", ev0); end
        n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL lu_ready_high got %b want 1", rdy0); end
        tick();
        if_valid = 1'b0;
        n_vec++; if ({ev0, ins0} !== {1'b1, ADD6}) begin n_err++; $display("FAIL lu_issue got v=%b instr=%h want 1/%h", ev0, ins0, ADD6); end
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (got_b(k) !== m_b[k]) begin n_err++; $display("FAIL lu_model dut%0d got %h want %h", k, got_b(k), m_b[k]); end
        end
`ifdef DECODE_STALL_CNT_EN
        n_vec++; if ((sc0 - st0) !== 32'd1 || sc0 !== m_st[0]) begin n_err++; $display("FAIL lu_stall_cnt got %0d want %0d", sc0, st0 + 32'd1); end
`endif
    endtask

    task automatic test_imm();
        drive(1'b1, BEQ, 32'h300, 1'b0, 1'b1);
        tick();
        drive(1'b1, LUI7, 32'h304, 1'b0, 1'b1);
        #1;
        n_vec++; if ({s1_0, s2_0} !== 10'd0) begin n_err++; $display("FAIL lui_sel got %0d/%0d want 0/0", s1_0, s2_0); end
        n_vec++; if (im0 !== 32'hFFFFFFF8) begin n_err++; $display("FAIL beq_imm got %h want fffffff8", im0); end
        tick();
        if_valid = 1'b0;
        n_vec++; if ({im0, rd0} !== {32'h12345000, 5'd7}) begin n_err++; $display("FAIL lui_imm got %h rd=%0d want 12345000 rd=7", im0, rd0); end
    endtask

    task automatic test_hold();
        drive(1'b1, ADDI1, 32'h400, 1'b0, 1'b1);
        tick();
        drive(1'b1, ADDI2, 32'h404, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++; if (rdy0 !== 1'b0) begin n_err++; $display("FAIL hold_ready c%0d got %b want 0", c, rdy0); end
            tick();
            n_vec++; if (got_b(0) !== m_b[0] || ins0 !== ADDI1) begin n_err++; $display("FAIL hold_bundle c%0d got %h want %h", c, got_b(0), m_b[0]); end
        end
        ex_ready = 1'b1;
        #1;
        n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", rdy0); end
        tick();
        n_vec++; if ({ev0, ins0, pc0} !== {1'b1, ADDI2, 32'h404}) begin n_err++; $display("FAIL release_load got %h/%h want %h/404", ins0, pc0, ADDI2); end
    endtask

    task automatic test_flush();
        drive(1'b1, ADD3, 32'h408, 1'b1, 1'b0);
        #1;
        n_vec++; if (rdy0 !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", rdy0); end
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        n_vec++; if ({ev0, ev1} !== 2'b00) begin n_err++; $display("FAIL flush_valid got %b%b want 00", ev0, ev1); end
    endtask

    task automatic test_illegal();
        drive(1'b1, ADD17, 32'h500, 1'b0, 1'b1);
        tick();
        n_vec++; if ({il0, il1, ev1} !== 3'b011) begin n_err++; $display("FAIL ill_reg got il32=%b il16=%b v16=%b want 0 1 1", il0, il1, ev1); end
        drive(1'b1, 32'h0000007F, 32'h504, 1'b0, 1'b1);
        tick();
        if_valid = 1'b0;
        n_vec++; if ({il0, il1, im0, rd0} !== {1'b1, 1'b1, 32'd0, 5'd0}) begin n_err++; $display("FAIL ill_op got il=%b%b imm=%h rd=%0d want 11/0/0", il0, il1, im0, rd0); end
    endtask

    task automatic test_random();
        logic [31:0] cur, pc;
        logic acc;
        cur = gen(); pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 3) != 0), cur, pc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
            #1;
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (got_comb(k) !== exp_comb(k)) begin n_err++; $display("FAIL rnd_comb c%0d dut%0d instr %h got %h want %h", c, k, cur, got_comb(k), exp_comb(k)); end
            end
            acc = if_valid && m_ready(0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_vec++; if (got_b(k) !== m_b[k]) begin n_err++; $display("FAIL rnd_bundle c%0d dut%0d got %h want %h", c, k, got_b(k), m_b[k]); end
`ifdef DECODE_STALL_CNT_EN
                n_vec++; if (got_st(k) !== m_st[k]) begin n_err++; $display("FAIL rnd_stall c%0d dut%0d got %0d want %0d", c, k, got_st(k), m_st[k]); end
`endif
            end
            if (acc) begin cur = gen(); pc = pc + 32'd4; end
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, LW5, 32'h600, 1'b0, 1'b1);
        tick();
        if_instr = ADD6;
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (got_b(k) !== m_b[k]) begin n_err++; $display("FAIL async_rst dut%0d got %h want %h", k, got_b(k), m_b[k]); end
            n_vec++; if (got_st(k) !== 32'd0) begin n_err++; $display("FAIL async_rst_stall dut%0d got %0d want 0", k, got_st(k)); end
        end
        if_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (ev0 !== 1'b0) begin n_err++; $display("FAIL post_rst_valid got %b want 0", ev0); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_add();
        test_load_use();
        test_imm();
        test_hold();
        test_flush();
        test_illegal();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
